// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA-3 squeeze/output path.
// Contents: mode encoding, Keccak state constants, and helpers that give the rate
// (bytes per squeezed block) and the total digest length for a command.
package sha3_pkg;

    localparam int unsigned KECCAK_STATE_W = 1600;
    localparam int unsigned LANE_W         = 64;

    typedef enum logic [2:0] {
        ModeSha3_224 = 3'd0,
        ModeSha3_256 = 3'd1,
        ModeSha3_384 = 3'd2,
        ModeSha3_512 = 3'd3,
        ModeShake128 = 3'd4,
        ModeShake256 = 3'd5,
        ModeFull     = 3'd6,
        ModeRsvd     = 3'd7
    } sha3_mode_e;

    // Reserved encoding behaves exactly like SHA3-256.
    function automatic logic [7:0] rate_bytes(sha3_mode_e mode);
        case (mode)
            ModeSha3_224: rate_bytes = 8'd144;
            ModeSha3_256: rate_bytes = 8'd136;
            ModeSha3_384: rate_bytes = 8'd104;
            ModeSha3_512: rate_bytes = 8'd72;
            ModeShake128: rate_bytes = 8'd168;
            ModeShake256: rate_bytes = 8'd136;
            ModeFull:     rate_bytes = 8'd200;
            default:      rate_bytes = 8'd136;
        endcase
    endfunction

    function automatic int unsigned digest_bytes(sha3_mode_e mode, int unsigned len);
        case (mode)
            ModeSha3_224: digest_bytes = 28;
            ModeSha3_256: digest_bytes = 32;
            ModeSha3_384: digest_bytes = 48;
            ModeSha3_512: digest_bytes = 64;
            ModeShake128: digest_bytes = len;
            ModeShake256: digest_bytes = len;
            ModeFull:     digest_bytes = 200;
            default:      digest_bytes = 32;
        endcase
    endfunction

endpackage

// File: rtl/sha3_squeeze_stream_if.sv
// AXI4-Stream bundle carrying digest bytes out of the squeeze block.
// Signals: tdata/tkeep/tvalid/tlast driven by the master, tready by the slave.
interface sha3_squeeze_stream_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sha3_beat_shifter.sv
// Rate-wide byte shift register feeding the output stream.
// Ports:
//   clk, rst   clock and synchronous active-high reset (clears the register)
//   load       capture the first `rate` bytes of load_data, zeroing the rest
//   shift      drop one beat worth of bytes (the current beat has been taken)
//   load_data  full Keccak state, stream byte k at [8k +: 8]
//   rate       number of valid bytes in a block
//   beat       current output beat, byte order set by MSB_FIRST
module sha3_beat_shifter
    import sha3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      shift,
    input  logic [KECCAK_STATE_W-1:0] load_data,
    input  logic [7:0]                rate,
    output logic [DATA_WIDTH-1:0]     beat
);
    localparam int unsigned BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int unsigned STATE_BYTES = KECCAK_STATE_W / 8;

    logic [KECCAK_STATE_W-1:0] sr_q;
    logic [KECCAK_STATE_W-1:0] masked;

    // Capacity bytes never leave the block.
    always_comb begin
        masked = '0;
        for (int k = 0; k < STATE_BYTES; k++) begin
            if (8'(k) < rate) begin
                masked[8*k +: 8] = load_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= masked;
        end else if (shift) begin
            sr_q <= sr_q >> DATA_WIDTH;
        end
    end

    // Oldest byte always sits at sr_q[7:0]; only the lane placement differs.
    always_comb begin
        beat = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (MSB_FIRST) begin
                beat[DATA_WIDTH-1-8*i -: 8] = sr_q[8*i +: 8];
            end else begin
                beat[8*i +: 8] = sr_q[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/sha3_squeeze_stream.sv
// Streams SHA3/SHAKE digest bytes (or the raw state) from the Keccak core onto AXI4-Stream.
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   cmd_valid/ready       command handshake; cmd_mode selects the function, cmd_len is
//                         the SHAKE output length in bytes
//   st_valid/ready        permuted state handshake, st_data is the 1600-bit state
//   perm_req              one-cycle request for another Keccak-f (SHAKE multi-block)
//   done                  one-cycle pulse when a command completes
//   m_axis                AXI4-Stream master carrying the digest
module sha3_squeeze_stream
    import sha3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_W      = 16,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_mode,
    input  logic [LEN_W-1:0]          cmd_len,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [KECCAK_STATE_W-1:0] st_data,
    output logic                      perm_req,
    output logic                      done,
    sha3_squeeze_stream_if.master     m_axis
);
    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
    // Full-state dumps need 200 even when LEN_W is narrow.
    localparam int unsigned CNT_W      = (LEN_W > 8) ? LEN_W : 8;

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64))
    begin : g_bad_width
        $error("sha3_squeeze_stream: DATA_WIDTH must be 8, 16, 32 or 64");
    end

    typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

    state_e             state_q;
    sha3_mode_e         mode_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [7:0]         blk_q;
    logic               cmd_ready_q;
    logic               st_ready_q;
    logic               tvalid_q;
    logic               perm_q;
    logic               done_q;

    logic [CNT_W-1:0]      cmd_bytes;
    logic [7:0]            cur_rate;
    logic                  last_beat;
    logic                  beat_fire;
    logic                  load_fire;
    logic [BEAT_BYTES-1:0] keep;
    logic [DATA_WIDTH-1:0] beat;

    assign cmd_bytes = CNT_W'(digest_bytes(sha3_mode_e'(cmd_mode), 32'(cmd_len)));
    assign cur_rate  = rate_bytes(mode_q);
    assign last_beat = remaining_q <= CNT_W'(BEAT_BYTES);
    assign beat_fire = tvalid_q && m_axis.tready;
    assign load_fire = (state_q == StLoad) && st_valid && st_ready_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= StIdle;
            mode_q      <= ModeSha3_224;
            remaining_q <= '0;
            blk_q       <= '0;
            cmd_ready_q <= 1'b0;
            st_ready_q  <= 1'b0;
            tvalid_q    <= 1'b0;
            perm_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            perm_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        if (cmd_bytes == '0) begin
                            // Zero-length SHAKE: nothing to stream, just complete.
                            done_q <= 1'b1;
                        end else begin
                            mode_q      <= sha3_mode_e'(cmd_mode);
                            remaining_q <= cmd_bytes;
                            cmd_ready_q <= 1'b0;
                            st_ready_q  <= 1'b1;
                            state_q     <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (load_fire) begin
                        st_ready_q <= 1'b0;
                        tvalid_q   <= 1'b1;
                        blk_q      <= cur_rate;
                        state_q    <= StStream;
                    end
                end
                StStream: begin
                    if (beat_fire) begin
                        if (last_beat) begin
                            tvalid_q    <= 1'b0;
                            remaining_q <= '0;
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            remaining_q <= remaining_q - CNT_W'(BEAT_BYTES);
                            blk_q       <= blk_q - 8'(BEAT_BYTES);
                            // Rate is a multiple of the beat, so blocks end on a beat boundary.
                            if (blk_q == 8'(BEAT_BYTES)) begin
                                tvalid_q   <= 1'b0;
                                perm_q     <= 1'b1;
                                st_ready_q <= 1'b1;
                                state_q    <= StLoad;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // remaining_q exceeds the beat size on every beat but the last, giving all-ones there.
    always_comb begin
        keep = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (MSB_FIRST) begin
                keep[BEAT_BYTES-1-i] = tvalid_q && (remaining_q > CNT_W'(i));
            end else begin
                keep[i] = tvalid_q && (remaining_q > CNT_W'(i));
            end
        end
    end

    sha3_beat_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shifter (
        .clk       (ACLK),
        .rst       (ARESET),
        .load      (load_fire),
        .shift     (beat_fire),
        .load_data (st_data),
        .rate      (cur_rate),
        .beat      (beat)
    );

    assign cmd_ready     = cmd_ready_q;
    assign st_ready      = st_ready_q;
    assign perm_req      = perm_q;
    assign done          = done_q;
    assign m_axis.tdata  = beat;
    assign m_axis.tkeep  = keep;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tvalid_q && last_beat;

endmodule

// File: tb/tb_sha3_squeeze_stream.sv
// Self-checking bench: four DUT variants (64b, 32b, 16b LSB-first, 16b MSB-first) share
// stimulus; the one selected by `sel` is driven and watched by a scoreboard monitor.
module tb_sha3_squeeze_stream;

    logic ACLK;
    logic ARESET;
    logic [3:0]    cv;
    logic [2:0]    cmd_mode;
    logic [15:0]   cmd_len;
    logic [3:0]    sv;
    logic [1599:0] st_data;
    logic          tready;

    wire [3:0]  cr, sr, pr, dn, tv, tl;
    wire [63:0] td [4];
    wire [7:0]  tk [4];

    int sel;
    int bp_mode;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        blk_end;
    } beat_t;

    beat_t exp_q[$];
    int n_tests, n_fail;
    int beat_cnt, done_cnt, perm_cnt;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    sha3_squeeze_stream_if #(.DATA_WIDTH(64)) if64 ();
    sha3_squeeze_stream_if #(.DATA_WIDTH(32)) if32 ();
    sha3_squeeze_stream_if #(.DATA_WIDTH(16)) if16 ();
    sha3_squeeze_stream_if #(.DATA_WIDTH(16)) if16m ();

    assign if64.tready  = tready;
    assign if32.tready  = tready;
    assign if16.tready  = tready;
    assign if16m.tready = tready;

    sha3_squeeze_stream #(.DATA_WIDTH(64), .LEN_W(16), .MSB_FIRST(1'b0)) u_dut64 (
        .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cv[0]), .cmd_ready(cr[0]),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len), .st_valid(sv[0]), .st_ready(sr[0]),
        .st_data(st_data), .perm_req(pr[0]), .done(dn[0]), .m_axis(if64)
    );
    sha3_squeeze_stream #(.DATA_WIDTH(32), .LEN_W(16), .MSB_FIRST(1'b0)) u_dut32 (
        .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cv[1]), .cmd_ready(cr[1]),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len), .st_valid(sv[1]), .st_ready(sr[1]),
        .st_data(st_data), .perm_req(pr[1]), .done(dn[1]), .m_axis(if32)
    );
    sha3_squeeze_stream #(.DATA_WIDTH(16), .LEN_W(16), .MSB_FIRST(1'b0)) u_dut16 (
        .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cv[2]), .cmd_ready(cr[2]),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len), .st_valid(sv[2]), .st_ready(sr[2]),
        .st_data(st_data), .perm_req(pr[2]), .done(dn[2]), .m_axis(if16)
    );
    sha3_squeeze_stream #(.DATA_WIDTH(16), .LEN_W(16), .MSB_FIRST(1'b1)) u_dut16m (
        .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cv[3]), .cmd_ready(cr[3]),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len), .st_valid(sv[3]), .st_ready(sr[3]),
        .st_data(st_data), .perm_req(pr[3]), .done(dn[3]), .m_axis(if16m)
    );

    assign td[0] = if64.tdata;
    assign td[1] = 64'(if32.tdata);
    assign td[2] = 64'(if16.tdata);
    assign td[3] = 64'(if16m.tdata);
    assign tk[0] = if64.tkeep;
    assign tk[1] = 8'(if32.tkeep);
    assign tk[2] = 8'(if16.tkeep);
    assign tk[3] = 8'(if16m.tkeep);
    assign tv = {if16m.tvalid, if16.tvalid, if32.tvalid, if64.tvalid};
    assign tl = {if16m.tlast, if16.tlast, if32.tlast, if64.tlast};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bb_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 4 : 2;
    endfunction

    function automatic bit msb_of(input int s);
        return s == 3;
    endfunction

    function automatic int rate_of(input int m);
        case (m)
            0: return 144;
            1: return 136;
            2: return 104;
            3: return 72;
            4: return 168;
            5: return 136;
            6: return 200;
            default: return 136;
        endcase
    endfunction

    function automatic int digest_of(input int m, input int len);
        case (m)
            0: return 28;
            1: return 32;
            2: return 48;
            3: return 64;
            4, 5: return len;
            6: return 200;
            default: return 32;
        endcase
    endfunction

    // Block 0 is byte k = k mod 256; later blocks are offset so a replay would be caught.
    function automatic logic [7:0] state_byte(input int b, input int k);
        return 8'((k + 37 * b) % 256);
    endfunction

    function automatic logic [1599:0] make_state(input int b);
        logic [1599:0] s;
        for (int k = 0; k < 200; k++) s[8*k +: 8] = state_byte(b, k);
        return s;
    endfunction

    task automatic push_block(input int b, input int rate, input int rem, input int s);
        int bb, nb, nbeats, idx, lane;
        beat_t e;
        bb = bb_of(s);
        nb = (rem < rate) ? rem : rate;
        nbeats = (nb + bb - 1) / bb;
        for (int j = 0; j < nbeats; j++) begin
            e.data = '0;
            e.keep = '0;
            for (int i = 0; i < bb; i++) begin
                idx = j * bb + i;
                if (idx < nb) begin
                    lane = msb_of(s) ? (bb - 1 - i) : i;
                    e.data[8*lane +: 8] = state_byte(b, idx);
                    e.keep[lane] = 1'b1;
                end
            end
            e.last    = (rem - j * bb) <= bb;
            e.blk_end = ((j + 1) * bb) == rate;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(posedge ACLK);
        #1 ARESET = 1'b1;
        cv = '0;
        sv = '0;
        @(posedge ACLK);
        @(negedge ACLK);
        exp_q.delete();
        check_eq("rst_ctrl_outputs", 64'({cr, sr, pr, dn, tv, tl}), 64'd0);
        check_eq("rst_tdata", td[sel], 64'd0);
        check_eq("rst_tkeep", 64'(tk[sel]), 64'd0);
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        check_eq("cmd_ready_before_edge", 64'(cr[sel]), 64'd0);
        @(negedge ACLK);
        check_eq("cmd_ready_after_rst", 64'(cr), 64'hf);
    endtask

    task automatic run_cmd(input int s, input int m, input int len, input int abort_at);
        int rem, b, d0, p0, dig, rate;
        dig  = digest_of(m, len);
        rate = rate_of(m);
        d0 = done_cnt;
        p0 = perm_cnt;
        beat_cnt = 0;
        sel = s;
        cmd_mode = 3'(m);
        cmd_len  = 16'(len);
        @(posedge ACLK);
        #1 cv[s] = 1'b1;
        for (int g = 0; g < 50; g++) begin
            @(negedge ACLK);
            if (cr[s]) break;
        end
        check_eq("cmd_ready", 64'(cr[s]), 64'd1);
        @(posedge ACLK);
        #1 cv[s] = 1'b0;
        rem = dig;
        b = 0;
        while (rem > 0) begin
            for (int g = 0; g < 2000; g++) begin
                @(negedge ACLK);
                if (sr[s]) break;
            end
            check_eq("st_ready", 64'(sr[s]), 64'd1);
            if (!sr[s]) break;
            push_block(b, rate, rem, s);
            @(posedge ACLK);
            #1 sv[s] = 1'b1;
            st_data = make_state(b);
            @(posedge ACLK);
            #1 sv[s] = 1'b0;
            rem -= (rem < rate) ? rem : rate;
            b++;
        end
        if (abort_at > 0) begin
            for (int g = 0; g < 500; g++) begin
                @(posedge ACLK);
                if (beat_cnt >= abort_at) break;
            end
            check_eq("beats_before_abort", 64'(beat_cnt), 64'(abort_at));
            do_reset();
            check_eq("no_done_on_abort", 64'(done_cnt - d0), 64'd0);
        end else begin
            for (int g = 0; g < 4000; g++) begin
                @(posedge ACLK);
                if (done_cnt != d0) break;
            end
            repeat (3) @(negedge ACLK);
            check_eq("done_count", 64'(done_cnt - d0), 64'd1);
            check_eq("all_beats_seen", 64'(exp_q.size()), 64'd0);
            check_eq("perm_count", 64'(perm_cnt - p0), 64'((b > 0) ? b - 1 : 0));
        end
    endtask

    // Monitor/scoreboard: sampled on the falling edge, events land on the next rising edge.
    initial begin
        bit exp_done, exp_perm, exp_tv, stall;
        logic [63:0] sd, mask;
        logic [7:0]  sk;
        logic        sl;
        beat_t       e;
        exp_done = 0; exp_perm = 0; exp_tv = 0; stall = 0;
        sd = '0; sk = '0; sl = 1'b0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                exp_done = 0; exp_perm = 0; exp_tv = 0; stall = 0;
            end else begin
                if (dn[sel] || exp_done) check_eq("done_pulse", 64'(dn[sel]), 64'(exp_done));
                if (dn[sel]) done_cnt++;
                if (pr[sel] || exp_perm) check_eq("perm_req_pulse", 64'(pr[sel]), 64'(exp_perm));
                if (pr[sel]) perm_cnt++;
                if (exp_tv) check_eq("tvalid_latency", 64'(tv[sel]), 64'd1);
                if (stall) begin
                    check_eq("hold_tvalid", 64'(tv[sel]), 64'd1);
                    check_eq("hold_tdata", td[sel], sd);
                    check_eq("hold_tkeep", 64'(tk[sel]), 64'(sk));
                    check_eq("hold_tlast", 64'(tl[sel]), 64'(sl));
                end
                exp_done = 0;
                exp_perm = 0;
                exp_tv = sv[sel] && sr[sel];
                stall  = tv[sel] && !tready;
                sd = td[sel];
                sk = tk[sel];
                sl = tl[sel];
                if (cv[sel] && cr[sel] && (cmd_mode == 3'd4 || cmd_mode == 3'd5) && cmd_len == 16'd0)
                    exp_done = 1;
                if (tv[sel] && tready) begin
                    beat_cnt++;
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", 64'(tv[sel]), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        mask = '0;
                        for (int i = 0; i < 8; i++) if (e.keep[i]) mask[8*i +: 8] = 8'hff;
                        check_eq("tdata", td[sel] & mask, e.data);
                        check_eq("tkeep", 64'(tk[sel]), 64'(e.keep));
                        check_eq("tlast", 64'(tl[sel]), 64'(e.last));
                        exp_done = e.last;
                        exp_perm = e.blk_end && !e.last;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            case (bp_mode)
                1:       tready = ~tready;
                2:       tready = 1'($urandom_range(0, 1));
                default: tready = 1'b1;
            endcase
        end
    end

    initial begin
        n_tests = 0; n_fail = 0;
        beat_cnt = 0; done_cnt = 0; perm_cnt = 0;
        ARESET = 1'b1;
        cv = '0; sv = '0;
        cmd_mode = '0; cmd_len = '0;
        st_data = '0;
        tready = 1'b1;
        bp_mode = 0;
        sel = 0;
        repeat (2) @(posedge ACLK);
        do_reset();

        run_cmd(0, 1, 0, 0);      // SHA3-256, 64b: 4 full beats
        run_cmd(0, 0, 0, 0);      // SHA3-224, 64b: last beat keep 0x0F
        run_cmd(1, 4, 200, 0);    // SHAKE128 200 bytes, 32b: 42 + 8 beats, one perm_req
        bp_mode = 1;
        run_cmd(2, 3, 0, 0);      // SHA3-512, 16b, alternating TREADY
        bp_mode = 0;
        run_cmd(3, 6, 0, 0);      // full state, 16b MSB-first, no perm_req
        run_cmd(0, 7, 0, 0);      // reserved mode behaves as SHA3-256
        run_cmd(1, 5, 0, 0);      // SHAKE256 zero length: done only
        bp_mode = 2;
        run_cmd(0, 5, 300, 0);    // SHAKE256 300 bytes: three blocks, random TREADY
        bp_mode = 0;
        run_cmd(0, 2, 0, 3);      // SHA3-384 aborted by reset after beat 3
        run_cmd(0, 1, 0, 0);      // clean SHA3-256 after the abort

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
